// File: rtl/rename_port_sched.sv
// rename_port_sched: arbitrates the single shared rename port (RAT + free list) between
// issuing decoded instructions and returning ROB-retired physical registers.
//  - dec_*            : decoded instruction offer (valid/ready), buffered in a 1-entry hold
//  - rob_ret_*        : retired physical register frees, buffered in an RQ_DEPTH-entry FIFO
//  - ren_*            : registered one-cycle grants (issue or retire) and rename results
//  - out_*            : registered pulse and captured physical registers of a renamed instruction
//  - stall_cycles     : saturating count of cycles spent stalled on an empty free list
module rename_port_sched #(
  parameter int unsigned RQ_DEPTH = 4,
  parameter int unsigned RQ_HI    = 3,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        rob_ret_valid,
  output logic        rob_ret_ready,
  input  logic [5:0]  rob_ret_phys,
  output logic        ren_issue_valid,
  output logic        ren_retire_valid,
  output logic [4:0]  ren_rs1,
  output logic [4:0]  ren_rs2,
  output logic [4:0]  ren_rd,
  output logic [5:0]  ren_retire_phys,
  input  logic        ren_rename_valid,
  input  logic [5:0]  ren_phys_rd,
  input  logic [5:0]  ren_phys_rs1,
  input  logic [5:0]  ren_phys_rs2,
  output logic        out_valid,
  output logic [5:0]  out_phys_rd,
  output logic [5:0]  out_phys_rs1,
  output logic [5:0]  out_phys_rs2,
  output logic [15:0] stall_cycles
);

  localparam int unsigned PtrW  = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(RQ_DEPTH + 1);
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  typedef enum logic {StRun, StStall} state_e;

  state_e            state_q, state_d;
  logic              hold_v_q, hold_v_d;
  logic [4:0]        hold_rs1_q, hold_rs1_d, hold_rs2_q, hold_rs2_d, hold_rd_q, hold_rd_d;
  logic [5:0]        rq_mem_q [RQ_DEPTH];
  logic [5:0]        rq_mem_d [RQ_DEPTH];
  logic [PtrW-1:0]   rq_rd_ptr_q, rq_rd_ptr_d, rq_wr_ptr_q, rq_wr_ptr_d;
  logic [CntW-1:0]   rq_cnt_q, rq_cnt_d, cnt_pp;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              issue_q, issue_d, retire_q, retire_d;
  logic [4:0]        ren_rs1_q, ren_rs1_d, ren_rs2_q, ren_rs2_d, ren_rd_q, ren_rd_d;
  logic [5:0]        ret_phys_q, ret_phys_d;
  logic              out_valid_q, out_valid_d;
  logic [5:0]        out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic [15:0]       stall_q, stall_d;
  logic              issue_done, accept, push;

  assign issue_done    = issue_q & ren_rename_valid;
  assign dec_ready     = ~hold_v_q | issue_done;
  assign rob_ret_ready = rq_cnt_q < CntW'(RQ_DEPTH);
  assign accept        = dec_valid & dec_ready;
  assign push          = rob_ret_valid & rob_ret_ready;

  always_comb begin
    // Hold register: a same-edge accept overrides the clear from issue_done.
    hold_v_d   = accept | (hold_v_q & ~issue_done);
    hold_rs1_d = accept ? dec_rs1 : hold_rs1_q;
    hold_rs2_d = accept ? dec_rs2 : hold_rs2_q;
    hold_rd_d  = accept ? dec_rd  : hold_rd_q;

    state_d = state_q;
    if (state_q == StRun && issue_q && !ren_rename_valid) begin
      state_d = StStall;
    end else if (state_q == StStall && retire_q) begin
      state_d = StRun;
    end

    // Counts cycles the FIFO held entries without a retire grant.
    if (retire_q || rq_cnt_q == '0) begin
      wait_d = '0;
    end else if (wait_q != WaitW'(MAX_WAIT)) begin
      wait_d = wait_q + WaitW'(1);
    end else begin
      wait_d = wait_q;
    end

    // Grant is decided on occupancy including this edge's push, so a push into an empty
    // FIFO can be granted immediately (head bypasses from rob_ret_phys).
    cnt_pp   = rq_cnt_q + CntW'(push);
    issue_d  = 1'b0;
    retire_d = 1'b0;
    if (state_d == StStall) begin
      retire_d = (cnt_pp != '0);
    end else if (cnt_pp >= CntW'(RQ_HI) || (cnt_pp != '0 && wait_d == WaitW'(MAX_WAIT))) begin
      retire_d = 1'b1;
    end else if (hold_v_d) begin
      issue_d = 1'b1;
    end else if (cnt_pp != '0) begin
      retire_d = 1'b1;
    end

    rq_mem_d    = rq_mem_q;
    rq_wr_ptr_d = rq_wr_ptr_q;
    rq_rd_ptr_d = rq_rd_ptr_q;
    if (push) begin
      rq_mem_d[rq_wr_ptr_q] = rob_ret_phys;
      rq_wr_ptr_d           = rq_wr_ptr_q + PtrW'(1);
    end
    if (retire_d) begin
      rq_rd_ptr_d = rq_rd_ptr_q + PtrW'(1);
    end
    rq_cnt_d = cnt_pp - CntW'(retire_d);

    ren_rs1_d  = issue_d ? hold_rs1_d : ren_rs1_q;
    ren_rs2_d  = issue_d ? hold_rs2_d : ren_rs2_q;
    ren_rd_d   = issue_d ? hold_rd_d  : ren_rd_q;
    ret_phys_d = retire_d ? ((rq_cnt_q == '0) ? rob_ret_phys : rq_mem_q[rq_rd_ptr_q])
                          : ret_phys_q;

    out_valid_d = issue_done;
    out_rd_d    = issue_done ? ren_phys_rd  : out_rd_q;
    out_rs1_d   = issue_done ? ren_phys_rs1 : out_rs1_q;
    out_rs2_d   = issue_done ? ren_phys_rs2 : out_rs2_q;

    stall_d = (state_q == StStall && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRun;
      hold_v_q    <= 1'b0;
      hold_rs1_q  <= '0;
      hold_rs2_q  <= '0;
      hold_rd_q   <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) rq_mem_q[i] <= '0;
      rq_rd_ptr_q <= '0;
      rq_wr_ptr_q <= '0;
      rq_cnt_q    <= '0;
      wait_q      <= '0;
      issue_q     <= 1'b0;
      retire_q    <= 1'b0;
      ren_rs1_q   <= '0;
      ren_rs2_q   <= '0;
      ren_rd_q    <= '0;
      ret_phys_q  <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_v_q    <= hold_v_d;
      hold_rs1_q  <= hold_rs1_d;
      hold_rs2_q  <= hold_rs2_d;
      hold_rd_q   <= hold_rd_d;
      rq_mem_q    <= rq_mem_d;
      rq_rd_ptr_q <= rq_rd_ptr_d;
      rq_wr_ptr_q <= rq_wr_ptr_d;
      rq_cnt_q    <= rq_cnt_d;
      wait_q      <= wait_d;
      issue_q     <= issue_d;
      retire_q    <= retire_d;
      ren_rs1_q   <= ren_rs1_d;
      ren_rs2_q   <= ren_rs2_d;
      ren_rd_q    <= ren_rd_d;
      ret_phys_q  <= ret_phys_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      stall_q     <= stall_d;
    end
  end

  assign ren_issue_valid  = issue_q;
  assign ren_retire_valid = retire_q;
  assign ren_rs1          = ren_rs1_q;
  assign ren_rs2          = ren_rs2_q;
  assign ren_rd           = ren_rd_q;
  assign ren_retire_phys  = ret_phys_q;
  assign out_valid        = out_valid_q;
  assign out_phys_rd      = out_rd_q;
  assign out_phys_rs1     = out_rs1_q;
  assign out_phys_rs2     = out_rs2_q;
  assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_rename_port_sched.sv
module tb_rename_port_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dec_valid = 1'b0, dec_ready;
  logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic        rob_ret_valid = 1'b0, rob_ret_ready;
  logic [5:0]  rob_ret_phys = '0;
  logic        ren_issue_valid, ren_retire_valid;
  logic [4:0]  ren_rs1, ren_rs2, ren_rd;
  logic [5:0]  ren_retire_phys;
  logic        ren_rename_valid = 1'b0;
  logic [5:0]  ren_phys_rd = '0, ren_phys_rs1 = '0, ren_phys_rs2 = '0;
  logic        out_valid;
  logic [5:0]  out_phys_rd, out_phys_rs1, out_phys_rs2;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rename_port_sched #(.RQ_DEPTH(4), .RQ_HI(3), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .rob_ret_valid(rob_ret_valid), .rob_ret_ready(rob_ret_ready), .rob_ret_phys(rob_ret_phys),
    .ren_issue_valid(ren_issue_valid), .ren_retire_valid(ren_retire_valid),
    .ren_rs1(ren_rs1), .ren_rs2(ren_rs2), .ren_rd(ren_rd), .ren_retire_phys(ren_retire_phys),
    .ren_rename_valid(ren_rename_valid), .ren_phys_rd(ren_phys_rd),
    .ren_phys_rs1(ren_phys_rs1), .ren_phys_rs2(ren_phys_rs2),
    .out_valid(out_valid), .out_phys_rd(out_phys_rd), .out_phys_rs1(out_phys_rs1),
    .out_phys_rs2(out_phys_rs2), .stall_cycles(stall_cycles)
  );

  wire [59:0] dut_vec = {dec_ready, rob_ret_ready, ren_issue_valid, ren_retire_valid,
                         ren_rs1, ren_rs2, ren_rd, ren_retire_phys, out_valid,
                         out_phys_rd, out_phys_rs1, out_phys_rs2, stall_cycles};

  // Reference model: transaction-level view of the port (queue of frees, held instruction).
  bit         m_hold_v, m_stall, m_issue, m_retire, m_ov;
  logic [4:0] m_h1, m_h2, m_hd, m_r1, m_r2, m_rd;
  logic [5:0] m_rq [$];
  logic [5:0] m_rp, m_o_rd, m_o_rs1, m_o_rs2;
  int         m_wait, m_sc;

  task automatic model_reset();
    m_hold_v = 0; m_stall = 0; m_issue = 0; m_retire = 0; m_ov = 0;
    m_h1 = '0; m_h2 = '0; m_hd = '0; m_r1 = '0; m_r2 = '0; m_rd = '0;
    m_rq.delete();
    m_rp = '0; m_o_rd = '0; m_o_rs1 = '0; m_o_rs2 = '0;
    m_wait = 0; m_sc = 0;
  endtask

  task automatic model_step();
    bit done, acc, push;
    int n;
    done = m_issue && ren_rename_valid;
    acc  = dec_valid && (!m_hold_v || done);
    push = rob_ret_valid && (m_rq.size() < 4);
    if (m_stall && m_sc < 65535) m_sc++;
    if (m_retire || m_rq.size() == 0) m_wait = 0;
    else if (m_wait < 4) m_wait++;
    if (!m_stall && m_issue && !ren_rename_valid) m_stall = 1;
    else if (m_stall && m_retire) m_stall = 0;
    m_ov = done;
    if (done) begin m_o_rd = ren_phys_rd; m_o_rs1 = ren_phys_rs1; m_o_rs2 = ren_phys_rs2; end
    if (acc) begin m_hold_v = 1; m_h1 = dec_rs1; m_h2 = dec_rs2; m_hd = dec_rd; end
    else if (done) m_hold_v = 0;
    if (push) m_rq.push_back(rob_ret_phys);
    n = m_rq.size();
    m_issue = 0; m_retire = 0;
    if (m_stall) m_retire = (n > 0);
    else if (n >= 3 || (n > 0 && m_wait == 4)) m_retire = 1;
    else if (m_hold_v) m_issue = 1;
    else if (n > 0) m_retire = 1;
    if (m_retire) m_rp = m_rq.pop_front();
    if (m_issue) begin m_r1 = m_h1; m_r2 = m_h2; m_rd = m_hd; end
  endtask

  function automatic logic [59:0] mdl_vec();
    logic rdy, rrdy;
    rdy  = !m_hold_v || (m_issue && ren_rename_valid);
    rrdy = m_rq.size() < 4;
    return {rdy, rrdy, m_issue, m_retire, m_r1, m_r2, m_rd, m_rp, m_ov,
            m_o_rd, m_o_rs1, m_o_rs2, 16'(m_sc)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid = 0; rob_ret_valid = 0; ren_rename_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    total++;
    if (dut_vec !== {2'b11, 58'd0}) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec, {2'b11, 58'd0});
    end
  endtask

  task automatic test_basic();
    test_reset();
    dec_valid = 1; dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = 5'd3;
    ren_rename_valid = 1; ren_phys_rd = 6'h2A; ren_phys_rs1 = 6'h11; ren_phys_rs2 = 6'h12;
    tick();
    dec_valid = 0;
    total++;
    if (ren_issue_valid !== 1'b1 || ren_rd !== 5'd3) begin
      bad++; $display("FAIL basic_issue got iv=%b rd=%0d exp iv=1 rd=3", ren_issue_valid, ren_rd);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_phys_rd !== 6'h2A) begin
      bad++; $display("FAIL basic_out got ov=%b rd=%h exp ov=1 rd=2a", out_valid, out_phys_rd);
    end
    tick();
    total++;
    if (dut_vec !== mdl_vec()) begin
      bad++; $display("FAIL basic_after got=%h exp=%h", dut_vec, mdl_vec());
    end
  endtask

  task automatic test_stall();
    int  done_cnt = 0;
    bit  seen = 0;
    test_reset();
    dec_valid = 1;
    for (int c = 0; c < 300 && !m_stall; c++) begin
      dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
      ren_phys_rd = 6'($urandom);
      ren_rename_valid = (done_cnt < 64);
      if (m_issue && ren_rename_valid) done_cnt++;
      tick();
      total++;
      if (dut_vec !== mdl_vec()) begin
        bad++; $display("FAIL stall_fill c=%0d got=%h exp=%h", c, dut_vec, mdl_vec());
      end
    end
    total++;
    if (!m_stall || done_cnt != 64) begin
      bad++; $display("FAIL stall_entry got issues=%0d exp 64 then stall", done_cnt);
    end
    dec_valid = 0; ren_rename_valid = 0;
    repeat (3) tick();
    total++;
    if (dec_ready !== 1'b0 || stall_cycles !== 16'd3) begin
      bad++; $display("FAIL stall_hold got rdy=%b sc=%0d exp rdy=0 sc=3", dec_ready, stall_cycles);
    end
    rob_ret_valid = 1; rob_ret_phys = 6'd5;
    tick();
    rob_ret_valid = 0;
    total++;
    if (ren_retire_valid !== 1'b1 || ren_retire_phys !== 6'd5) begin
      bad++; $display("FAIL stall_retire got rv=%b p=%0d exp rv=1 p=5", ren_retire_valid,
                      ren_retire_phys);
    end
    ren_rename_valid = 1; ren_phys_rd = 6'd5;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      total++;
      if (dut_vec !== mdl_vec()) begin
        bad++; $display("FAIL stall_resume c=%0d got=%h exp=%h", c, dut_vec, mdl_vec());
      end
      if (out_valid === 1'b1) seen = 1;
    end
    total++;
    if (!seen || out_phys_rd !== 6'd5) begin
      bad++; $display("FAIL stall_reissue got seen=%b rd=%0d exp seen=1 rd=5", seen, out_phys_rd);
    end
  endtask

  task automatic test_starve();
    int lat = 0;
    bit seen = 0;
    test_reset();
    dec_valid = 1; ren_rename_valid = 1;
    tick();
    rob_ret_valid = 1; rob_ret_phys = 6'($urandom);
    tick();
    rob_ret_valid = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      dec_rs1 = 5'($urandom); dec_rd = 5'($urandom);
      tick();
      lat++;
      total++;
      if (ren_issue_valid && ren_retire_valid) begin
        bad++; $display("FAIL starve_excl c=%0d got both grants exp one", c);
      end
      total++;
      if (dut_vec !== mdl_vec()) begin
        bad++; $display("FAIL starve_vec c=%0d got=%h exp=%h", c, dut_vec, mdl_vec());
      end
      if (ren_retire_valid === 1'b1) seen = 1;
    end
    total++;
    if (!seen || lat > 5) begin
      bad++; $display("FAIL starve_latency got seen=%b lat=%0d exp lat<=5", seen, lat);
    end
  endtask

  task automatic test_rq_hi();
    int ret_cnt = 0, first = 0;
    test_reset();
    dec_valid = 1; ren_rename_valid = 1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      rob_ret_valid = (c <= 3); rob_ret_phys = 6'(40 + c);
      tick();
      total++;
      if (dut_vec !== mdl_vec()) begin
        bad++; $display("FAIL rqhi_vec c=%0d got=%h exp=%h", c, dut_vec, mdl_vec());
      end
      if (ren_retire_valid === 1'b1) begin
        ret_cnt++;
        if (first == 0) first = c;
      end
    end
    total++;
    if (ret_cnt != 3 || first != 3) begin
      bad++; $display("FAIL rqhi_order got n=%0d first=%0d exp n=3 first=3", ret_cnt, first);
    end
  endtask

  task automatic test_full_and_reset();
    test_reset();
    dec_valid = 1; ren_rename_valid = 0;
    repeat (2) tick();
    dec_valid = 0;
    total++;
    if (dut_vec !== mdl_vec() || !m_stall) begin
      bad++; $display("FAIL full_stall got=%h exp=%h", dut_vec, mdl_vec());
    end
    for (int c = 0; c < 7; c++) begin
      rob_ret_valid = (c < 5); rob_ret_phys = 6'($urandom);
      tick();
      total++;
      if (dut_vec !== mdl_vec()) begin
        bad++; $display("FAIL full_push c=%0d got=%h exp=%h", c, dut_vec, mdl_vec());
      end
    end
    dec_valid = 1; ren_rename_valid = 0;
    repeat (2) tick();
    rob_ret_valid = 1; rob_ret_phys = 6'd9;
    tick();
    #2 reset_n = 0;
    #1;
    model_reset();
    idle_inputs();
    total++;
    if (dut_vec !== {2'b11, 58'd0}) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec, {2'b11, 58'd0});
    end
    @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
      rob_ret_valid = ($urandom_range(0, 2) == 0);
      rob_ret_phys = 6'($urandom);
      ren_rename_valid = ($urandom_range(0, 7) != 0);
      ren_phys_rd = 6'($urandom); ren_phys_rs1 = 6'($urandom); ren_phys_rs2 = 6'($urandom);
      tick();
      total++;
      if (dut_vec !== mdl_vec()) begin
        bad++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, mdl_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_starve();
    test_rq_hi();
    test_full_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
